// File: rtl/bus_pkg.sv
// Shared encodings for the SRAM-like bus arbiter: access sizes, owner tags
// and grant state machine states.
package bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/owner_fifo.sv
// In-order record of which master owns each accepted bus transaction.
// One bit per entry; full/empty come from an occupancy count.
module owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the instruction and data requesters:
// data-priority address arbitration, grant held until accepted, in-order response routing.
//
//   state  | meaning
//   IDLE   | no forwarded request pending; grant picks data first, then inst
//   HOLD_I | inst request forwarded but not yet accepted; grant locked to inst
//   HOLD_D | data request forwarded but not yet accepted; grant locked to data
module sram_bus_arbiter
    import bus_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,

    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [3:0]        wstrb,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [31:0]       rdata,

    output logic              busy,
    output logic              proto_err
);

    arb_state_e state_q;
    logic       proto_err_q;
    logic       gnt_own;
    logic       gnt_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       push;
    logic       pop;

    assign gnt_own = (state_q == HOLD_D) ? OWN_DATA :
                     (state_q == HOLD_I) ? OWN_INST :
                     (data_req ? OWN_DATA : OWN_INST);

    assign gnt_req = (gnt_own == OWN_DATA) ? data_req : inst_req;

    // Full blocks req regardless of a same-cycle pop, so data_ok never reaches req.
    assign req   = gnt_req && !fifo_full;
    assign wr    = (gnt_own == OWN_DATA) ? data_wr    : inst_wr;
    assign size  = (gnt_own == OWN_DATA) ? data_size  : inst_size;
    assign wstrb = (gnt_own == OWN_DATA) ? data_wstrb : inst_wstrb;
    assign addr  = (gnt_own == OWN_DATA) ? data_addr  : inst_addr;
    assign wdata = (gnt_own == OWN_DATA) ? data_wdata : inst_wdata;

    assign push = req && addr_ok;
    assign pop  = data_ok && !fifo_empty;

    assign inst_addr_ok = push && (gnt_own == OWN_INST);
    assign data_addr_ok = push && (gnt_own == OWN_DATA);
    assign inst_data_ok = pop && (fifo_head == OWN_INST);
    assign data_data_ok = pop && (fifo_head == OWN_DATA);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign busy      = !fifo_empty;
    assign proto_err = proto_err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            proto_err_q <= 1'b0;
        end else begin
            if (data_ok && fifo_empty) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (req && !addr_ok) begin
                        state_q <= (gnt_own == OWN_DATA) ? HOLD_D : HOLD_I;
                    end
                end
                HOLD_I: begin
                    if (addr_ok || !inst_req) begin
                        state_q <= IDLE;
                    end
                end
                HOLD_D: begin
                    if (addr_ok || !data_req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (gnt_own),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: arbitration, grant hold, full/empty
// FIFO boundaries, response routing, sticky protocol error and async reset.
module tb_sram_bus_arbiter;
    import bus_pkg::*;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, size;
    logic [3:0]  inst_wstrb, data_wstrb, wstrb;
    logic [31:0] inst_addr, data_addr, addr;
    logic [31:0] inst_wdata, data_wdata, wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, rdata;
    logic        req, wr, addr_ok, data_ok, busy, proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    sram_bus_arbiter #(.OUTSTANDING(2), .ADDR_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .req          (req),
        .wr           (wr),
        .size         (size),
        .wstrb        (wstrb),
        .addr         (addr),
        .wdata        (wdata),
        .addr_ok      (addr_ok),
        .data_ok      (data_ok),
        .rdata        (rdata),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_wstrb = 4'hF;
        data_req = 0; data_wr = 0; data_size = SZ_WORD; data_wstrb = 4'hF;
        inst_wdata = 32'h1111_0000; data_wdata = 32'h2222_0000;
        addr_ok = 0; data_ok = 0; rdata = 32'h0;
    endtask

    // Inputs change at the falling edge; outputs are checked 1 ns later.
    task automatic cyc();
        @(negedge clk);
        clr();
    endtask

    initial begin
        clr();
        inst_addr = 32'h0; data_addr = 32'h0;
        resetn = 1'b0;
        #1;
        chk("rst_req",  32'(req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_aok",  32'({inst_addr_ok, data_addr_ok}), 0);
        chk("rst_dok",  32'({inst_data_ok, data_data_ok}), 0);
        chk("rst_perr", 32'(proto_err), 0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;

        // both request together: data wins, then inst, responses in order
        cyc(); inst_req = 1; data_req = 1; addr_ok = 1;
        inst_addr = 32'h100; data_addr = 32'h200; data_size = SZ_HALF; data_wr = 1;
        #1;
        chk("t1_addr",     addr, 32'h200);
        chk("t1_size",     32'(size), 32'(SZ_HALF));
        chk("t1_wr",       32'(wr), 1);
        chk("t1_daok",     32'(data_addr_ok), 1);
        chk("t1_iaok",     32'(inst_addr_ok), 0);
        cyc(); inst_req = 1; addr_ok = 1; #1;
        chk("t1_addr2",    addr, 32'h100);
        chk("t1_iaok2",    32'(inst_addr_ok), 1);
        chk("t1_busy",     32'(busy), 1);
        cyc(); data_ok = 1; rdata = 32'hAAAA; #1;
        chk("t1_rsp1",     32'({inst_data_ok, data_data_ok}), 32'b01);
        chk("t1_rdata1",   data_rdata, 32'hAAAA);
        cyc(); data_ok = 1; rdata = 32'hBBBB; #1;
        chk("t1_rsp2",     32'({inst_data_ok, data_data_ok}), 32'b10);
        chk("t1_rdata2",   inst_rdata, 32'hBBBB);
        cyc(); #1;
        chk("t1_idle",     32'(busy), 0);

        // inst held while addr_ok low; data arriving later cannot overtake
        inst_addr = 32'h300; data_addr = 32'h400;
        cyc(); inst_req = 1; #1;
        chk("t2_c1_addr",  addr, 32'h300);
        chk("t2_c1_req",   32'(req), 1);
        cyc(); inst_req = 1; data_req = 1; #1;
        chk("t2_c2_addr",  addr, 32'h300);
        chk("t2_c2_state", 32'(dut.state_q), 32'(HOLD_I));
        chk("t2_c2_aok",   32'({inst_addr_ok, data_addr_ok}), 0);
        cyc(); inst_req = 1; data_req = 1; #1;
        chk("t2_c3_addr",  addr, 32'h300);
        cyc(); inst_req = 1; data_req = 1; addr_ok = 1; #1;
        chk("t2_c4_iaok",  32'(inst_addr_ok), 1);
        chk("t2_c4_daok",  32'(data_addr_ok), 0);
        cyc(); inst_req = 1; data_req = 1; addr_ok = 1; #1;
        chk("t2_c5_addr",  addr, 32'h400);
        chk("t2_c5_daok",  32'(data_addr_ok), 1);
        chk("t2_c5_iaok",  32'(inst_addr_ok), 0);
        cyc(); data_ok = 1; #1;
        chk("t2_rsp1",     32'({inst_data_ok, data_data_ok}), 32'b10);
        cyc(); data_ok = 1; #1;
        chk("t2_rsp2",     32'({inst_data_ok, data_data_ok}), 32'b01);

        // full FIFO blocks req even with a same-cycle pop
        cyc(); data_req = 1; addr_ok = 1; data_addr = 32'h500; #1;
        chk("t3_aok1",     32'(data_addr_ok), 1);
        cyc(); data_req = 1; addr_ok = 1; data_addr = 32'h504; #1;
        chk("t3_aok2",     32'(data_addr_ok), 1);
        cyc(); data_req = 1; addr_ok = 1; data_ok = 1; data_addr = 32'h508; #1;
        chk("t3_full_busy", 32'(busy), 1);
        chk("t3_full_req", 32'(req), 0);
        chk("t3_full_aok", 32'(data_addr_ok), 0);
        chk("t3_full_dok", 32'(data_data_ok), 1);
        cyc(); data_req = 1; addr_ok = 1; data_addr = 32'h508; #1;
        chk("t3_next_req", 32'(req), 1);
        chk("t3_next_aok", 32'(data_addr_ok), 1);
        cyc(); data_ok = 1; #1;
        chk("t3_drain1",   32'(data_data_ok), 1);
        cyc(); data_ok = 1; #1;
        chk("t3_drain2",   32'(data_data_ok), 1);

        // push and pop together
        cyc(); inst_req = 1; addr_ok = 1; #1;
        chk("t4_iaok",     32'(inst_addr_ok), 1);
        cyc(); data_req = 1; addr_ok = 1; data_ok = 1; #1;
        chk("t4_daok",     32'(data_addr_ok), 1);
        chk("t4_pp_rsp",   32'({inst_data_ok, data_data_ok}), 32'b10);
        cyc(); data_ok = 1; #1;
        chk("t4_rsp2",     32'({inst_data_ok, data_data_ok}), 32'b01);
        cyc(); #1;
        chk("t4_empty",    32'(busy), 0);

        // response with nothing outstanding
        cyc(); data_ok = 1; #1;
        chk("t5_dok",      32'({inst_data_ok, data_data_ok}), 0);
        chk("t5_perr0",    32'(proto_err), 0);
        cyc(); #1;
        chk("t5_perr1",    32'(proto_err), 1);
        chk("t5_busy",     32'(busy), 0);
        cyc(); #1;
        chk("t5_perr2",    32'(proto_err), 1);

        // async reset while in HOLD_D with one outstanding
        cyc(); inst_req = 1; addr_ok = 1; #1;
        chk("t6_iaok",     32'(inst_addr_ok), 1);
        cyc(); data_req = 1; #1;
        chk("t6_req",      32'(req), 1);
        cyc(); data_req = 1; #1;
        chk("t6_state",    32'(dut.state_q), 32'(HOLD_D));
        chk("t6_busy",     32'(busy), 1);
        chk("t6_perr",     32'(proto_err), 1);
        #1 resetn = 1'b0;
        #1;
        chk("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_perr", 32'(proto_err), 0);
        data_req = 0;
        #1;
        chk("t6_rst_req",  32'(req), 0);
        @(negedge clk);
        resetn = 1'b1;
        cyc(); #1;
        chk("t6_post_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
